// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: register control
// codes, adder operation codes and the sequencer state encoding.
package booth_pkg;

  // Register control codes shared by the Q, A and M registers
  localparam logic [1:0] CTRL_LOAD  = 2'b00;
  localparam logic [1:0] CTRL_RESET = 2'b01;
  localparam logic [1:0] CTRL_SHIFT = 2'b10;
  localparam logic [1:0] CTRL_HOLD  = 2'b11;

  // Adder operation select
  localparam logic [1:0] ALU_NONE = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_ARITH = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Booth recoding of the current multiplier bit pair {Q0, Q(-1)}:
  // 01 adds M, 10 subtracts M, 00/11 need no arithmetic.
  function automatic logic [1:0] boothDecode(input logic q0, input logic qm1);
    logic [1:0] op;
    case ({q0, qm1})
      2'b01:   op = ALU_ADD;
      2'b10:   op = ALU_SUB;
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_iter_cnt.sv
// Iteration down-counter for the Booth sequencer. Loaded with the operand
// width at the start of a multiply, decremented once per shift, and flags
// the final iteration when it reaches one.
module booth_iter_cnt #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic last
);

  logic [CNT_W-1:0] count;

  // Load has priority; decrement saturates at zero so the count never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(WIDTH);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/booth_ctrl.sv
// Sequencing FSM for the radix-2 Booth multiplier datapath. Drives the Q/A
// register controls, the M load and the adder select, and owns Q(-1) and the
// iteration counter. All outputs are decoded from registered state only.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       q0,
  input  logic       qShiftBit,
  output logic [1:0] qCtrl,
  output logic [1:0] aCtrl,
  output logic       mLoad,
  output logic [1:0] aluOp,
  output logic       qm1,
  output logic       busy,
  output logic       done
);

  state_t     state;
  state_t     nextState;
  logic [1:0] opReg;
  logic [1:0] evalOp;
  logic       lastIter;

  assign evalOp = boothDecode(q0, qm1);

  booth_iter_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == ST_LOAD),
    .dec   (state == ST_SHIFT),
    .last  (lastIter)
  );

  // State register; reset aborts any multiply in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Q(-1) is cleared on load and captures the bit shifted out of Q;
  // the Booth op chosen in EVAL is held for the following ARITH cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qm1   <= 1'b0;
      opReg <= ALU_NONE;
    end else begin
      if (state == ST_LOAD) begin
        qm1 <= 1'b0;
      end else if (state == ST_SHIFT) begin
        qm1 <= qShiftBit;
      end
      if (state == ST_EVAL) begin
        opReg <= evalOp;
      end
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    nextState = state;
    qCtrl     = CTRL_HOLD;
    aCtrl     = CTRL_HOLD;
    mLoad     = 1'b0;
    aluOp     = ALU_NONE;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          nextState = ST_LOAD;
        end
      end
      ST_LOAD: begin
        qCtrl     = CTRL_LOAD;
        aCtrl     = CTRL_RESET;
        mLoad     = 1'b1;
        nextState = ST_EVAL;
      end
      ST_EVAL: begin
        nextState = (evalOp == ALU_NONE) ? ST_SHIFT : ST_ARITH;
      end
      ST_ARITH: begin
        aCtrl     = CTRL_LOAD;
        aluOp     = opReg;
        nextState = ST_SHIFT;
      end
      ST_SHIFT: begin
        qCtrl     = CTRL_SHIFT;
        aCtrl     = CTRL_SHIFT;
        nextState = lastIter ? ST_DONE : ST_EVAL;
      end
      ST_DONE: begin
        done      = 1'b1;
        nextState = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        nextState = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/booth_ctrl.md
Name: booth_ctrl

Overview:
- Sequencing FSM for the radix-2 Booth multiplier datapath.
- Drives the 2-bit ctrl codes of the Q register (multiplier) and A register (accumulator), the M register load, and the add/sub select of the adder.
- Owns the Q(-1) bit and the iteration counter.
- start/done handshake to the surrounding system.

Parameters:
- WIDTH, 4, operand width; number of Booth iterations.
- CNT_W, 3, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin multiply; sampled only in IDLE.
- q0  input  1  LSB of Q register output (o[0]).
- qShiftBit  input  1  Q register shiftBit output (bit shifted out).
- qCtrl  output  2  Q register control.
- aCtrl  output  2  A register control, same encoding as qCtrl.
- mLoad  output  1  load multiplicand into M register.
- aluOp  output  2  00 = none, 01 = A+M, 10 = A-M.
- qm1  output  1  current Q(-1) bit.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; product is valid in A:Q.

Behaviour:
- Control encoding: LOAD=00, RESET=01, SHIFT=10, HOLD=11.
- Reset (async, rst_n=0): state=IDLE, qCtrl=aCtrl=HOLD, mLoad=0, aluOp=00, qm1=0, count=0, busy=0, done=0.
  - Reset mid-operation aborts immediately. No done pulse is issued.
- All outputs are registered-state decodes (Moore). Defaults unless stated: qCtrl=aCtrl=HOLD, mLoad=0, aluOp=00.
- IDLE: if start=1, next state is LOAD.
- LOAD (1 cycle):
  - qCtrl=LOAD, aCtrl=RESET, mLoad=1.
  - At the edge: qm1<=0, count<=WIDTH.
  - Next state: EVAL.
- EVAL (1 cycle): decode {q0,qm1}.
  - 01 → ARITH with add.
  - 10 → ARITH with sub.
  - 00 or 11 → SHIFT.
  - The chosen op is latched into an internal opReg.
- ARITH (1 cycle):
  - aCtrl=LOAD (A captures adder result), aluOp=opReg.
  - Next state: SHIFT.
- SHIFT (1 cycle):
  - qCtrl=SHIFT, aCtrl=SHIFT.
  - At the edge: qm1<=qShiftBit, count<=count-1.
  - If count==1, next state is DONE; otherwise EVAL.
  - The datapath wires A LSB to the Q register carry input; this block does not.
- DONE (1 cycle): done=1, busy=1. Next state: IDLE.
- start is ignored while busy; no queueing.
- start held high continuously restarts a new multiply on the cycle after DONE.
- Latency from the start-sampling edge to the done cycle is 2 + Σ(iteration cost), where iteration cost is 2 (shift only) or 3 (arith + shift).
  - WIDTH=4: minimum 10 cycles, maximum 14 cycles.
- count never wraps: it is decremented only in SHIFT, and only while count ≥ 1.
- q0 and qShiftBit are don't-care outside EVAL and SHIFT respectively.

Decomposition:
- Shared package booth_pkg holds:
  - the ctrl constants CTRL_LOAD/CTRL_RESET/CTRL_SHIFT/CTRL_HOLD, reused by the Q, A and M registers;
  - the ALU_NONE/ALU_ADD/ALU_SUB codes;
  - the FSM state enum.
- One natural sub-module, booth_iter_cnt: loadable down-counter with a last flag (count==1). The FSM stays in booth_ctrl.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT → all outputs go to reset values asynchronously, before the next edge; state is IDLE after release.
- Multiplier 0000: bench models Q, start=1 for one cycle.
  - Required: LOAD, then 4× (EVAL, SHIFT), aluOp stays 00 throughout.
  - done pulses 10 cycles after the start edge; busy falls the cycle after.
- Multiplier 0101, multiplicand 0011:
  - Required op sequence SUB, ADD, SUB, ADD; done at cycle 14.
  - Datapath-in-loop A:Q = 00001111 (15).
- Multiplier 1111, multiplicand 0010:
  - Required: SUB on the first iteration, then shift-only; done at cycle 11.
  - Datapath-in-loop A:Q = 11111110 (-2).
- start pulsed during ARITH → ignored: no extra LOAD, and exactly one done pulse.
- start held high → back-to-back multiplies: LOAD follows DONE→IDLE with exactly one IDLE cycle between them; qm1 is re-cleared to 0.
